// File: rtl/aes_mk_pkg.sv
// Shared definitions for the multi-key cipher wrapper: FSM states, register
// word indices, CTRL field positions and register-lock bit positions.
package aes_mk_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StWait  = 2'd2
    } state_e;

    // Word indices (bus_addr_i[8:2])
    localparam logic [6:0] IDX_CTRL   = 7'd0;
    localparam logic [6:0] IDX_STATUS = 7'd1;
    localparam logic [6:0] IDX_DATA   = 7'd2;
    localparam logic [6:0] IDX_RESULT = 7'd16;
    localparam logic [6:0] IDX_KEY    = 7'd32;

    // CTRL field positions
    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_ABORT  = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    // reglk_ctrl_i bit positions
    localparam int unsigned LK_CTRL_RD   = 0;
    localparam int unsigned LK_CTRL_WR   = 1;
    localparam int unsigned LK_DATA_RD   = 2;
    localparam int unsigned LK_DATA_WR   = 3;
    localparam int unsigned LK_RESULT_RD = 4;
    localparam int unsigned LK_KEY_WR    = 5;
    localparam int unsigned LK_STATUS_RD = 6;
    localparam int unsigned LK_STATUS_WR = 7;

endpackage

// File: rtl/aes_mk_regfile.sv
// Key slot storage: NUM_KEYS slots of KEY_WORDS words, write-only from the bus.
// The read port returns one whole slot, word 0 in the MSBs, for the core.
module aes_mk_regfile #(
    parameter int unsigned NUM_KEYS  = 3,
    parameter int unsigned KEY_WORDS = 6
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      key_we_i,
    input  logic [3:0]                key_slot_i,
    input  logic [2:0]                key_word_i,
    input  logic [31:0]               key_wdata_i,
    input  logic [3:0]                rd_slot_i,
    output logic [32*KEY_WORDS-1:0]   rd_key_o
);

    logic [31:0] r_slot [NUM_KEYS][KEY_WORDS];

    // One key word written per accepted bus write
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                for (int unsigned w = 0; w < KEY_WORDS; w++) begin
                    r_slot[k][w] <= 32'h0;
                end
            end
        end else if (key_we_i) begin
            for (int unsigned k = 0; k < NUM_KEYS; k++) begin
                for (int unsigned w = 0; w < KEY_WORDS; w++) begin
                    if (key_slot_i == 4'(k) && key_word_i == 3'(w)) begin
                        r_slot[k][w] <= key_wdata_i;
                    end
                end
            end
        end
    end

    // Slot select mux, packed with word 0 in the MSBs
    always_comb begin
        rd_key_o = '0;
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
            if (rd_slot_i == 4'(k)) begin
                for (int unsigned w = 0; w < KEY_WORDS; w++) begin
                    rd_key_o[32*(KEY_WORDS-w)-1 -: 32] = r_slot[k][w];
                end
            end
        end
    end

endmodule

// File: rtl/aes_multikey_wrapper.sv
// Bus-programmable wrapper around a cipher core with several key slots.
// Holds CTRL/STATUS/DATA/RESULT, launches the core and waits for its result.
module aes_multikey_wrapper
    import aes_mk_pkg::*;
#(
    parameter int unsigned NUM_KEYS  = 3,
    parameter int unsigned KEY_WORDS = 6,
    parameter int unsigned BLK_WORDS = 4,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [7:0]              reglk_ctrl_i,
    input  logic                    bus_valid_i,
    input  logic                    bus_write_i,
    input  logic [31:0]             bus_addr_i,
    input  logic [31:0]             bus_wdata_i,
    input  logic [3:0]              bus_wstrb_i,
    output logic [31:0]             bus_rdata_o,
    output logic                    bus_ready_o,
    output logic                    bus_error_o,
    output logic                    core_start_o,
    output logic [32*KEY_WORDS-1:0] core_key_o,
    output logic [32*BLK_WORDS-1:0] core_data_o,
    input  logic [32*BLK_WORDS-1:0] core_out_i,
    input  logic                    core_valid_i,
    output logic                    irq_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    state_e                 r_state;
    logic                   r_ready, r_error, r_start;
    logic [31:0]            r_rdata;
    logic [CntW-1:0]        r_cnt;
    logic                   r_irq_en, r_done, r_timeout, r_lock_err;
    logic [3:0]             r_key_sel;
    logic [31:0]            r_data   [BLK_WORDS];
    logic [31:0]            r_result [BLK_WORDS];
    logic [32*KEY_WORDS-1:0] r_core_key;
    logic [32*BLK_WORDS-1:0] r_core_data;

    logic        w_accept, w_wr, w_rd, w_busy;
    logic [6:0]  w_idx, w_data_word, w_res_word, w_key_off;
    logic        w_is_ctrl, w_is_status, w_is_data, w_is_result, w_is_key;
    logic        w_lock_viol, w_reject, w_wr_ok, w_abort, w_go;
    logic [31:0] w_rdata;
    logic [32*KEY_WORDS-1:0] w_sel_key;
    logic [32*BLK_WORDS-1:0] w_data_packed;
    logic        w_unused;

    assign w_unused = ^{bus_wstrb_i, bus_addr_i[31:9], bus_addr_i[1:0]};

    // A request is sampled only while ready is low, giving one access per 2 cycles
    assign w_accept = bus_valid_i & ~r_ready;
    assign w_wr     = w_accept & bus_write_i;
    assign w_rd     = w_accept & ~bus_write_i;
    assign w_idx    = bus_addr_i[8:2];
    assign w_busy   = (r_state != StIdle);

    // Address decode
    always_comb begin
        w_data_word = w_idx - IDX_DATA;
        w_res_word  = w_idx - IDX_RESULT;
        w_key_off   = w_idx - IDX_KEY;
        w_is_ctrl   = (w_idx == IDX_CTRL);
        w_is_status = (w_idx == IDX_STATUS);
        w_is_data   = (w_idx >= IDX_DATA) && (w_idx < IDX_DATA + 7'(BLK_WORDS));
        w_is_result = (w_idx >= IDX_RESULT) && (w_idx < IDX_RESULT + 7'(BLK_WORDS));
        w_is_key    = (w_idx >= IDX_KEY) && (w_key_off[6:3] < 4'(NUM_KEYS))
                      && ({1'b0, w_key_off[2:0]} < 4'(KEY_WORDS));
    end

    // Write qualification: lock violations first, then busy / bad key_sel rejects
    always_comb begin
        w_lock_viol = 1'b0;
        w_reject    = 1'b0;
        if (w_wr) begin
            if (w_is_ctrl) begin
                if (reglk_ctrl_i[LK_CTRL_WR]) begin
                    w_lock_viol = 1'b1;
                end else if (bus_wdata_i[CTRL_START] && !bus_wdata_i[CTRL_ABORT]
                             && (w_busy || bus_wdata_i[7:4] >= 4'(NUM_KEYS))) begin
                    w_reject = 1'b1;
                end
            end else if (w_is_status) begin
                w_lock_viol = reglk_ctrl_i[LK_STATUS_WR];
            end else if (w_is_data) begin
                if (reglk_ctrl_i[LK_DATA_WR]) w_lock_viol = 1'b1;
                else if (w_busy)              w_reject    = 1'b1;
            end else if (w_is_key) begin
                if (reglk_ctrl_i[LK_KEY_WR]) w_lock_viol = 1'b1;
                else if (w_busy)             w_reject    = 1'b1;
            end
        end
    end

    assign w_wr_ok = w_wr & ~w_lock_viol & ~w_reject;
    assign w_abort = w_wr_ok & w_is_ctrl & bus_wdata_i[CTRL_ABORT];
    assign w_go    = w_wr_ok & w_is_ctrl & bus_wdata_i[CTRL_START] & ~bus_wdata_i[CTRL_ABORT];

    // Read data mux; locked, key and unmapped reads return 0
    always_comb begin
        w_rdata = 32'h0;
        if (w_is_ctrl) begin
            if (!reglk_ctrl_i[LK_CTRL_RD]) w_rdata = {24'h0, r_key_sel, 1'b0, r_irq_en, 2'b00};
        end else if (w_is_status) begin
            if (!reglk_ctrl_i[LK_STATUS_RD]) w_rdata = {28'h0, r_lock_err, r_timeout, r_done, w_busy};
        end else if (w_is_data) begin
            if (!reglk_ctrl_i[LK_DATA_RD]) begin
                for (int unsigned i = 0; i < BLK_WORDS; i++) begin
                    if (w_data_word == 7'(i)) w_rdata = r_data[i];
                end
            end
        end else if (w_is_result) begin
            if (!reglk_ctrl_i[LK_RESULT_RD]) begin
                for (int unsigned i = 0; i < BLK_WORDS; i++) begin
                    if (w_res_word == 7'(i)) w_rdata = r_result[i];
                end
            end
        end
    end

    // DATA words packed for the core, word 0 in the MSBs
    always_comb begin
        w_data_packed = '0;
        for (int unsigned i = 0; i < BLK_WORDS; i++) begin
            w_data_packed[32*(BLK_WORDS-i)-1 -: 32] = r_data[i];
        end
    end

    aes_mk_regfile #(
        .NUM_KEYS  (NUM_KEYS),
        .KEY_WORDS (KEY_WORDS)
    ) u_regfile (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .key_we_i    (w_wr_ok & w_is_key),
        .key_slot_i  (w_key_off[6:3]),
        .key_word_i  (w_key_off[2:0]),
        .key_wdata_i (bus_wdata_i),
        .rd_slot_i   (bus_wdata_i[7:4]),
        .rd_key_o    (w_sel_key)
    );

    // Bus response, register updates and the IDLE/START/WAIT sequencer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= StIdle;
            r_ready     <= 1'b0;
            r_error     <= 1'b0;
            r_rdata     <= 32'h0;
            r_start     <= 1'b0;
            r_cnt       <= '0;
            r_irq_en    <= 1'b0;
            r_key_sel   <= 4'h0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_lock_err  <= 1'b0;
            r_core_key  <= '0;
            r_core_data <= '0;
            for (int unsigned i = 0; i < BLK_WORDS; i++) begin
                r_data[i]   <= 32'h0;
                r_result[i] <= 32'h0;
            end
        end else begin
            r_ready <= w_accept;
            r_rdata <= w_rd ? w_rdata : 32'h0;
            r_error <= w_lock_viol | w_reject;
            r_start <= 1'b0;

            if (w_lock_viol) r_lock_err <= 1'b1;
            if (w_wr_ok && w_is_status) begin
                if (bus_wdata_i[1]) r_done     <= 1'b0;
                if (bus_wdata_i[2]) r_timeout  <= 1'b0;
                if (bus_wdata_i[3]) r_lock_err <= 1'b0;
            end
            if (w_wr_ok && w_is_ctrl) begin
                r_irq_en  <= bus_wdata_i[CTRL_IRQ_EN];
                r_key_sel <= bus_wdata_i[7:4];
            end
            if (w_wr_ok && w_is_data) begin
                for (int unsigned i = 0; i < BLK_WORDS; i++) begin
                    if (w_data_word == 7'(i)) r_data[i] <= bus_wdata_i;
                end
            end

            unique case (r_state)
                StIdle: begin
                    if (w_go) begin
                        r_state     <= StStart;
                        r_start     <= 1'b1;
                        r_core_key  <= w_sel_key;
                        r_core_data <= w_data_packed;
                        r_done      <= 1'b0;
                        r_timeout   <= 1'b0;
                        r_cnt       <= '0;
                    end
                end
                StStart: begin
                    r_state <= w_abort ? StIdle : StWait;
                end
                StWait: begin
                    if (w_abort) begin
                        r_state <= StIdle;
                    end else if (core_valid_i) begin
                        r_state <= StIdle;
                        r_done  <= 1'b1;
                        for (int unsigned i = 0; i < BLK_WORDS; i++) begin
                            r_result[i] <= core_out_i[32*(BLK_WORDS-i)-1 -: 32];
                        end
                    end else if (r_cnt == CntW'(TIMEOUT - 1)) begin
                        r_state   <= StIdle;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus_ready_o  = r_ready;
    assign bus_rdata_o  = r_rdata;
    assign bus_error_o  = r_error;
    assign core_start_o = r_start;
    assign core_key_o   = r_core_key;
    assign core_data_o  = r_core_data;
    assign irq_o        = r_done & r_irq_en;

endmodule

// File: tb/tb_aes_multikey_wrapper.sv
// Self-checking bench for aes_multikey_wrapper: directed steps plus randomized
// register traffic, checked against a register-level reference model.
module tb_aes_multikey_wrapper;

    localparam int NK = 3;
    localparam int KW = 6;
    localparam int BW = 4;
    localparam int TO = 64;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [7:0]        reglk_ctrl_i = 8'h0;
    logic              bus_valid_i = 1'b0;
    logic              bus_write_i = 1'b0;
    logic [31:0]       bus_addr_i = 32'h0;
    logic [31:0]       bus_wdata_i = 32'h0;
    logic [3:0]        bus_wstrb_i = 4'h0;
    logic [31:0]       bus_rdata_o;
    logic              bus_ready_o;
    logic              bus_error_o;
    logic              core_start_o;
    logic [32*KW-1:0]  core_key_o;
    logic [32*BW-1:0]  core_data_o;
    logic [32*BW-1:0]  core_out_i = '0;
    logic              core_valid_i = 1'b0;
    logic              irq_o;

    always #5 clk_i = ~clk_i;

    aes_multikey_wrapper #(
        .NUM_KEYS  (NK),
        .KEY_WORDS (KW),
        .BLK_WORDS (BW),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .reglk_ctrl_i (reglk_ctrl_i),
        .bus_valid_i  (bus_valid_i),
        .bus_write_i  (bus_write_i),
        .bus_addr_i   (bus_addr_i),
        .bus_wdata_i  (bus_wdata_i),
        .bus_wstrb_i  (bus_wstrb_i),
        .bus_rdata_o  (bus_rdata_o),
        .bus_ready_o  (bus_ready_o),
        .bus_error_o  (bus_error_o),
        .core_start_o (core_start_o),
        .core_key_o   (core_key_o),
        .core_data_o  (core_data_o),
        .core_out_i   (core_out_i),
        .core_valid_i (core_valid_i),
        .irq_o        (irq_o)
    );

    int n_chk = 0;
    int n_err = 0;
    int n_start = 0;
    logic [32*KW-1:0] cap_key;
    logic [32*BW-1:0] cap_data;

    // Reference model state
    logic [31:0] m_key [NK][KW];
    logic [31:0] m_data [BW];
    logic [31:0] m_result [BW];
    logic        m_irq_en, m_busy, m_done, m_timeout, m_lock_err;
    logic [3:0]  m_key_sel;

    // Start-pulse monitor
    always @(negedge clk_i) begin
        if (core_start_o) begin
            n_start = n_start + 1;
            cap_key  = core_key_o;
            cap_data = core_data_o;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no finish, required finish within 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {28'h0, m_lock_err, m_timeout, m_done, m_busy};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NK; k++) for (int w = 0; w < KW; w++) m_key[k][w] = 32'h0;
        for (int i = 0; i < BW; i++) begin
            m_data[i]   = 32'h0;
            m_result[i] = 32'h0;
        end
        m_irq_en = 0; m_busy = 0; m_done = 0; m_timeout = 0; m_lock_err = 0; m_key_sel = 0;
    endtask

    // Register map rules for an access made while the wrapper is idle
    function automatic void model_access(input bit wr, input int idx, input logic [31:0] wd,
                                         input logic [7:0] lk, output logic [31:0] rd,
                                         output logic err);
        int k, w;
        rd = 32'h0;
        err = 1'b0;
        k = (idx - 32) / 8;
        w = (idx - 32) % 8;
        if (idx == 0) begin
            if (wr) begin
                if (lk[1]) begin err = 1; m_lock_err = 1; end
                else begin m_irq_en = wd[2]; m_key_sel = wd[7:4]; end
            end else if (!lk[0]) rd = {24'h0, m_key_sel, 1'b0, m_irq_en, 2'b00};
        end else if (idx == 1) begin
            if (wr) begin
                if (lk[7]) begin err = 1; m_lock_err = 1; end
                else begin
                    if (wd[1]) m_done = 0;
                    if (wd[2]) m_timeout = 0;
                    if (wd[3]) m_lock_err = 0;
                end
            end else if (!lk[6]) rd = m_status();
        end else if (idx >= 2 && idx < 2 + BW) begin
            if (wr) begin
                if (lk[3]) begin err = 1; m_lock_err = 1; end
                else m_data[idx-2] = wd;
            end else if (!lk[2]) rd = m_data[idx-2];
        end else if (idx >= 16 && idx < 16 + BW) begin
            if (!wr && !lk[4]) rd = m_result[idx-16];
        end else if (idx >= 32 && k < NK && w < KW) begin
            if (wr) begin
                if (lk[5]) begin err = 1; m_lock_err = 1; end
                else m_key[k][w] = wd;
            end
        end
    endfunction

    task automatic bus_xfer(input bit wr, input int idx, input logic [31:0] wd,
                            output logic [31:0] rd, output logic err);
        bit got;
        got = 0;
        rd = 32'h0;
        err = 1'b0;
        @(negedge clk_i);
        bus_valid_i = 1'b1;
        bus_write_i = wr;
        bus_addr_i  = 32'(idx) << 2;
        bus_wdata_i = wd;
        bus_wstrb_i = 4'hF;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk_i);
            if (bus_ready_o) begin
                got = 1;
                rd  = bus_rdata_o;
                err = bus_error_o;
            end
        end
        bus_valid_i = 1'b0;
        bus_write_i = 1'b0;
        check("bus_ready", 32'(got), 32'd1);
    endtask

    task automatic wr_exp(input int idx, input logic [31:0] wd, input logic exp_err,
                          input string tag);
        logic [31:0] rd;
        logic err;
        bus_xfer(1'b1, idx, wd, rd, err);
        check(tag, 32'(err), 32'(exp_err));
    endtask

    task automatic rd_exp(input int idx, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        logic err;
        bus_xfer(1'b0, idx, 32'h0, rd, err);
        check(tag, rd, exp);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic start_exp(input logic [3:0] sel, input logic irq);
        int base;
        base = n_start;
        wr_exp(0, {24'h0, sel, 1'b0, irq, 2'b01}, 1'b0, "start_err");
        #1;
        check("start_pulse", 32'(n_start), 32'(base + 1));
        for (int w = 0; w < KW; w++) check("core_key", cap_key[32*(KW-w)-1 -: 32], m_key[sel][w]);
        for (int i = 0; i < BW; i++) check("core_data", cap_data[32*(BW-i)-1 -: 32], m_data[i]);
        m_key_sel = sel; m_irq_en = irq;
        m_busy = 1; m_done = 0; m_timeout = 0;
    endtask

    task automatic finish_exp(input logic [31:0] r0, input logic [31:0] r1,
                              input logic [31:0] r2, input logic [31:0] r3);
        logic [31:0] res [BW];
        res[0] = r0; res[1] = r1; res[2] = r2; res[3] = r3;
        @(negedge clk_i);
        for (int i = 0; i < BW; i++) core_out_i[32*(BW-i)-1 -: 32] = res[i];
        core_valid_i = 1'b1;
        @(negedge clk_i);
        core_valid_i = 1'b0;
        for (int i = 0; i < BW; i++) m_result[i] = res[i];
        m_done = 1; m_busy = 0;
    endtask

    initial begin
        logic [31:0] rd, exp_rd, wd;
        logic        err, exp_err;
        logic [7:0]  lk;
        int          idx, base;
        bit          wr;

        // Reset state
        model_reset();
        repeat (2) @(negedge clk_i);
        check("rst_ready", 32'(bus_ready_o), 32'd0);
        check("rst_rdata", bus_rdata_o, 32'h0);
        check("rst_error", 32'(bus_error_o), 32'd0);
        check("rst_start", 32'(core_start_o), 32'd0);
        check("rst_key_or", 32'(|core_key_o), 32'd0);
        check("rst_data_or", 32'(|core_data_o), 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
        rst_ni = 1'b1;
        rd_exp(1, m_status(), "status_reset");
        rd_exp(0, 32'h0, "ctrl_reset");

        // Random key material in every slot
        for (int k = 0; k < NK; k++) begin
            for (int w = 0; w < KW; w++) begin
                wd = $urandom;
                wr_exp(32 + 8*k + w, wd, 1'b0, "key_wr");
                m_key[k][w] = wd;
            end
        end

        // Directed operation on slot 1
        for (int w = 0; w < KW; w++) begin
            wr_exp(32 + 8 + w, 32'(w + 1), 1'b0, "key1_wr");
            m_key[1][w] = 32'(w + 1);
        end
        for (int i = 0; i < BW; i++) begin
            wr_exp(2 + i, 32'hA + 32'(i), 1'b0, "data_wr");
            m_data[i] = 32'hA + 32'(i);
        end
        start_exp(4'd1, 1'b0);
        rd_exp(1, m_status(), "status_busy");
        finish_exp(32'hF0, 32'hF1, 32'hF2, 32'hF3);
        for (int i = 0; i < BW; i++) rd_exp(16 + i, 32'hF0 + 32'(i), "result_directed");
        rd_exp(1, 32'h2, "status_done");
        check("irq_disabled", 32'(irq_o), 32'd0);
        check("one_pulse", 32'(n_start), 32'd1);

        // Randomized operations
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < BW; i++) begin
                wd = $urandom;
                wr_exp(2 + i, wd, 1'b0, "data_rand_wr");
                m_data[i] = wd;
            end
            start_exp(4'($urandom_range(0, NK - 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(1, 10)) @(negedge clk_i);
            finish_exp($urandom, $urandom, $urandom, $urandom);
            for (int i = 0; i < BW; i++) rd_exp(16 + i, m_result[i], "result_rand");
            rd_exp(1, m_status(), "status_rand");
            rd_exp(0, {24'h0, m_key_sel, 1'b0, m_irq_en, 2'b00}, "ctrl_rand");
            check("irq_level", 32'(irq_o), 32'(m_done & m_irq_en));
        end

        // Random register traffic with random locks while idle
        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 5))
                0: idx = 0;
                1: idx = 1;
                2: idx = 2 + int'($urandom_range(0, BW - 1));
                3: idx = 16 + int'($urandom_range(0, BW - 1));
                4: idx = 32 + 8 * int'($urandom_range(0, NK - 1)) + int'($urandom_range(0, 7));
                default: idx = int'($urandom_range(0, 127));
            endcase
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            if (idx == 0) wd[1:0] = 2'b00;
            lk = 8'($urandom & $urandom);
            reglk_ctrl_i = lk;
            bus_xfer(wr, idx, wd, rd, err);
            model_access(wr, idx, wd, lk, exp_rd, exp_err);
            check("rand_rdata", rd, exp_rd);
            check("rand_error", 32'(err), 32'(exp_err));
        end
        reglk_ctrl_i = 8'h0;
        rd_exp(1, m_status(), "status_after_rand");
        for (int k = 0; k < NK; k++) begin
            start_exp(4'(k), 1'b1);
            finish_exp($urandom, $urandom, $urandom, $urandom);
            check("irq_on", 32'(irq_o), 32'd1);
        end

        // Key write lock
        wr_exp(1, 32'hE, 1'b0, "status_clear");
        m_done = 0; m_timeout = 0; m_lock_err = 0;
        reglk_ctrl_i = 8'h20;
        wr_exp(32, 32'hDEADBEEF, 1'b1, "key_locked_err");
        m_lock_err = 1;
        rd_exp(1, 32'h8, "status_lock_err");
        wr_exp(1, 32'h8, 1'b0, "status_w1c");
        m_lock_err = 0;
        rd_exp(1, 32'h0, "status_cleared");
        reglk_ctrl_i = 8'h0;
        start_exp(4'd0, 1'b0);
        finish_exp(32'h11, 32'h22, 32'h33, 32'h44);

        // Timeout
        wr_exp(1, 32'hE, 1'b0, "status_clear2");
        m_done = 0;
        start_exp(4'd2, 1'b1);
        repeat (5) @(negedge clk_i);
        rd_exp(1, 32'h1, "status_wait");
        repeat (TO + 4) @(negedge clk_i);
        m_busy = 0; m_timeout = 1;
        rd_exp(1, 32'h4, "status_timeout");
        rd_exp(16, 32'h11, "result_kept_timeout");
        check("irq_timeout", 32'(irq_o), 32'd0);

        // Abort, start while busy, DATA write while busy
        start_exp(4'd1, 1'b0);
        repeat (3) @(negedge clk_i);
        wr_exp(0, {24'h0, 4'd1, 4'b0010}, 1'b0, "abort_err");
        m_busy = 0;
        rd_exp(1, 32'h0, "status_abort");
        rd_exp(17, 32'h22, "result_kept_abort");
        start_exp(4'd0, 1'b0);
        base = n_start;
        wr_exp(0, {24'h0, 4'd0, 4'b0001}, 1'b1, "start_busy_err");
        wr_exp(2, 32'h5555AAAA, 1'b1, "data_busy_err");
        wr_exp(32, 32'h5555AAAA, 1'b1, "key_busy_err");
        #1;
        check("no_pulse_busy", 32'(n_start), 32'(base));
        rd_exp(2, m_data[0], "data_kept_busy");
        wr_exp(0, {24'h0, 4'd0, 4'b0010}, 1'b0, "abort2_err");
        m_busy = 0;
        wr_exp(0, {24'h0, 4'd1, 4'b0011}, 1'b0, "start_abort_err");
        m_key_sel = 4'd1;
        repeat (2) @(negedge clk_i);
        check("no_pulse_start_abort", 32'(n_start), 32'(base));
        rd_exp(1, 32'h0, "status_idle");

        // Out-of-range key_sel
        wr_exp(0, {24'h0, 4'(NK), 4'b0001}, 1'b1, "bad_sel_err");
        repeat (2) @(negedge clk_i);
        check("no_pulse_bad_sel", 32'(n_start), 32'(base));
        rd_exp(0, {24'h0, m_key_sel, 1'b0, m_irq_en, 2'b00}, "ctrl_bad_sel");

        // Reset while waiting
        start_exp(4'd2, 1'b1);
        repeat (4) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("rstw_ready", 32'(bus_ready_o), 32'd0);
        check("rstw_start", 32'(core_start_o), 32'd0);
        check("rstw_key_or", 32'(|core_key_o), 32'd0);
        check("rstw_data_or", 32'(|core_data_o), 32'd0);
        check("rstw_irq", 32'(irq_o), 32'd0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        core_out_i = {BW{32'hCAFEF00D}};
        core_valid_i = 1'b1;
        @(negedge clk_i);
        core_valid_i = 1'b0;
        rd_exp(1, 32'h0, "status_after_rst");
        rd_exp(16, 32'h0, "result_after_rst");
        rd_exp(0, 32'h0, "ctrl_after_rst");
        check("irq_after_rst", 32'(irq_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
